// File: rtl/trace_pkg.sv
// Shared types and constants for the trace record packer.
// TRACE_TIMESTAMP_EN adds a 64-bit push timestamp to every record.
package trace_pkg;

   localparam logic [7:0] TRACE_MAGIC = 8'hA5;

   localparam int EV_W     = 7;
   localparam int COMMIT_W = 128;
   localparam int VALID_W  = 200;
   localparam int SEQ_W    = 32;
   localparam int TS_W     = 64;
   localparam int WORD_W   = 64;

   localparam int HDR_MAGIC_LSB = 56;
   localparam int HDR_EV_LSB    = 49;
   localparam int HDR_NW_LSB    = 45;
   localparam int HDR_NW_W      = 4;
   localparam int HDR_MULTI_BIT = 44;
   localparam int HDR_TS_BIT    = 43;
   localparam int HDR_SEQ_LSB   = 0;

`ifdef TRACE_TIMESTAMP_EN
   localparam logic TS_FLAG = 1'b1;
`else
   localparam logic TS_FLAG = 1'b0;
`endif

   typedef struct packed {
      logic [EV_W-1:0]     ev;
      logic [COMMIT_W-1:0] commit;
      logic [VALID_W-1:0]  valid;
      logic [SEQ_W-1:0]    seq;
`ifdef TRACE_TIMESTAMP_EN
      logic [TS_W-1:0]     ts;
`endif
   } trace_rec_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAY
   } ser_state_t;

   function automatic logic sec_onehot(input logic [4:0] sec);
      return (sec != 5'd0) && ((sec & (sec - 5'd1)) == 5'd0);
   endfunction

   function automatic logic sec_multi(input logic [4:0] sec);
      return (sec != 5'd0) && !sec_onehot(sec);
   endfunction

   function automatic logic [3:0] rec_nwords(input logic c,
                                             input logic [4:0] sec);
      return (c ? 4'd2 : 4'd0)
           + (sec_onehot(sec) ? 4'd4 : 4'd0)
           + (TS_FLAG ? 4'd1 : 4'd0);
   endfunction

endpackage

// File: rtl/trace_record_packer_if.sv
// Serialized trace word read port.
// Master drives words, slave returns ready.
interface trace_record_packer_if;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        rd_last;

   modport master (
      output rd_data, rd_valid, rd_last,
      input  rd_ready
   );

   modport slave (
      input  rd_data, rd_valid, rd_last,
      output rd_ready
   );
endinterface

// File: rtl/trace_rec_fifo.sv
// Synchronous record FIFO with full/empty/count.
// Push while full is ignored; count is pre-edge occupancy.
module trace_rec_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   s_axi_aclk,
   input  logic                   s_axi_aresetn,
   input  logic                   i_push,
   input  trace_rec_t             i_wdata,
   input  logic                   i_pop,
   output trace_rec_t             o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);

   trace_rec_t      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // storage write; contents need no reset
   always_ff @(posedge s_axi_aclk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // pointer and occupancy tracking
   always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
      if (s_axi_aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/trace_record_packer.sv
// Frames difftest events into records, queues and serializes them.
// TRACE_TIMESTAMP_EN appends a push-time cycle stamp to each record.
module trace_record_packer
   import trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 32
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   input  logic                     en,
   input  logic [EV_W-1:0]          event_valid,
   input  logic [COMMIT_W-1:0]      commitevent,
   input  logic [VALID_W-1:0]       validevent,
   trace_record_packer_if.master    rd,
   output logic [$clog2(DEPTH):0]   rec_count,
   output logic [DROP_W-1:0]        drop_count,
   output logic                     overflow,
   input  logic                     clr_stats
);
   logic [EV_W-1:0]   r_ev_d;
   logic [SEQ_W-1:0]  r_seq;
   logic [DROP_W-1:0] r_drop;
   logic              r_ovf;
   trace_rec_t        r_hold;
   ser_state_t        r_state;
   ser_state_t        w_state_nxt;
   logic [2:0]        r_idx;
   logic [2:0]        w_idx_nxt;
   trace_rec_t        w_rec;
   trace_rec_t        w_fifo_rd;
   logic              w_push_req;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic [3:0]        w_nwords;
   logic              w_c;
   logic              w_s;
   logic [2:0]        w_sidx;
   logic [63:0]       w_hdr;
   logic [63:0]       w_pay;
   logic [63:0]       w_rd_data;
   logic              w_rd_valid;
   logic              w_rd_last;
   logic              w_pay_last;
`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]   r_ts;

   // free-running cycle stamp
   always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
      if (s_axi_aresetn) r_ts <= '0;
      else               r_ts <= r_ts + 1'b1;
   end
`endif

   // payloads arrive one cycle after the event vector
   always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
      if (s_axi_aresetn) r_ev_d <= '0;
      else               r_ev_d <= en ? event_valid : '0;
   end

   assign w_push_req = (r_ev_d != '0);

   // record assembled from the aligned event and payloads
   always_comb begin
      w_rec        = '0;
      w_rec.ev     = r_ev_d;
      w_rec.commit = commitevent;
      w_rec.valid  = validevent;
      w_rec.seq    = r_seq;
`ifdef TRACE_TIMESTAMP_EN
      w_rec.ts     = r_ts;
`endif
   end

   trace_rec_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .s_axi_aclk    (s_axi_aclk),
      .s_axi_aresetn (s_axi_aresetn),
      .i_push        (w_push_req),
      .i_wdata       (w_rec),
      .i_pop         (w_pop),
      .o_rdata       (w_fifo_rd),
      .o_full        (w_full),
      .o_empty       (w_empty),
      .o_count       (rec_count)
   );

   // sequence numbers advance only on accepted records
   always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
      if (s_axi_aresetn)               r_seq <= '0;
      else if (w_push_req && !w_full)  r_seq <= r_seq + 1'b1;
   end

   // drop statistics; clear beats a same-cycle drop
   always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
      if (s_axi_aresetn) begin
         r_drop <= '0;
         r_ovf  <= 1'b0;
      end else if (clr_stats) begin
         r_drop <= '0;
         r_ovf  <= 1'b0;
      end else if (w_push_req && w_full) begin
         if (r_drop != '1) r_drop <= r_drop + 1'b1;
         r_ovf <= 1'b1;
      end
   end

   assign drop_count = r_drop;
   assign overflow   = r_ovf;

   assign w_c      = r_hold.ev[0];
   assign w_s      = sec_onehot(r_hold.ev[5:1]);
   assign w_nwords = rec_nwords(w_c, r_hold.ev[5:1]);

   // header word of the held record
   always_comb begin
      w_hdr = '0;
      w_hdr[HDR_MAGIC_LSB +: 8]       = TRACE_MAGIC;
      w_hdr[HDR_EV_LSB +: EV_W]       = r_hold.ev;
      w_hdr[HDR_NW_LSB +: HDR_NW_W]   = w_nwords;
      w_hdr[HDR_MULTI_BIT]            = sec_multi(r_hold.ev[5:1]);
      w_hdr[HDR_TS_BIT]               = TS_FLAG;
      w_hdr[HDR_SEQ_LSB +: SEQ_W]     = r_hold.seq;
   end

   // payload word select: commit pair, secondary quad, then stamp
   always_comb begin
      w_pay  = '0;
      w_sidx = r_idx - (w_c ? 3'd2 : 3'd0);
      if (w_c && r_idx < 3'd2) begin
         w_pay = r_idx[0] ? r_hold.commit[63:0] : r_hold.commit[127:64];
      end else if (w_s && w_sidx < 3'd4) begin
         unique case (w_sidx[1:0])
            2'd0: w_pay = {56'b0, r_hold.valid[199:192]};
            2'd1: w_pay = r_hold.valid[191:128];
            2'd2: w_pay = r_hold.valid[127:64];
            2'd3: w_pay = r_hold.valid[63:0];
         endcase
      end
`ifdef TRACE_TIMESTAMP_EN
      else begin
         w_pay = r_hold.ts;
      end
`endif
   end

   assign w_pay_last = ({1'b0, r_idx} == (w_nwords - 4'd1));

   // serializer next-state and read-port outputs
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_pop       = 1'b0;
      w_rd_valid  = 1'b0;
      w_rd_data   = '0;
      w_rd_last   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            w_rd_valid = 1'b1;
            w_rd_data  = w_hdr;
            w_rd_last  = (w_nwords == 4'd0);
            if (rd.rd_ready) begin
               w_idx_nxt   = 3'd0;
               w_state_nxt = (w_nwords == 4'd0) ? ST_IDLE : ST_PAY;
            end
         end
         ST_PAY: begin
            w_rd_valid = 1'b1;
            w_rd_data  = w_pay;
            w_rd_last  = w_pay_last;
            if (rd.rd_ready) begin
               w_idx_nxt = r_idx + 3'd1;
               if (w_pay_last) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // serializer state, word index and holding register
   always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
      if (s_axi_aresetn) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_pop) r_hold <= w_fifo_rd;
      end
   end

   assign rd.rd_valid = w_rd_valid;
   assign rd.rd_data  = w_rd_data;
   assign rd.rd_last  = w_rd_last;
endmodule

// File: tb/tb_trace_record_packer.sv
// Directed bench for trace_record_packer with a queue-level record model.
// Build with TRACE_TIMESTAMP_EN to cover the stamped record format.
module tb_trace_record_packer;
   localparam int DEPTH = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [6:0]   event_valid;
   logic [127:0] commitevent;
   logic [199:0] validevent;
   logic         clr_stats;
   logic [4:0]   rec_count;
   logic [31:0]  drop_count;
   logic         overflow;

   trace_record_packer_if rd_if();

   trace_record_packer #(
      .DEPTH  (DEPTH),
      .DROP_W (32)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst),
      .en            (en),
      .event_valid   (event_valid),
      .commitevent   (commitevent),
      .validevent    (validevent),
      .rd            (rd_if),
      .rec_count     (rec_count),
      .drop_count    (drop_count),
      .overflow      (overflow),
      .clr_stats     (clr_stats)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   typedef struct {
      logic [63:0] w [8];
      int          n;
   } rec_t;

   rec_t        fq [$];
   rec_t        act;
   bit          act_v;
   int          idx;
   logic [6:0]  ev_m;
   logic [31:0] seq_m;
   logic [31:0] drops_m;
   bit          ovf_m;
   logic [63:0] cyc_m;
   int          sz_m;
   bit          popn_m;

   // record as the read port must emit it, words in order
   function automatic rec_t mk(input logic [6:0] ev, input logic [127:0] c,
                               input logic [199:0] v, input logic [31:0] sq,
                               input logic [63:0] ts);
      rec_t r;
      int   k;
      int   ones;
      bit   tsf;
      for (int i = 0; i < 8; i++) r.w[i] = ts;
      ones = $countones(ev[5:1]);
      k    = 1;
      tsf  = 1'b0;
      if (ev[0]) begin
         r.w[k] = c[127:64]; r.w[k+1] = c[63:0]; k += 2;
      end
      if (ones == 1) begin
         r.w[k]   = {56'b0, v[199:192]};
         r.w[k+1] = v[191:128];
         r.w[k+2] = v[127:64];
         r.w[k+3] = v[63:0];
         k += 4;
      end
`ifdef TRACE_TIMESTAMP_EN
      r.w[k] = ts; k += 1; tsf = 1'b1;
`endif
      r.w[0] = {8'hA5, ev, 4'(k-1), (ones > 1), tsf, 11'b0, sq};
      r.n    = k;
      return r;
   endfunction

   // model advances on each clock from pre-edge inputs only
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fq.delete();
         act_v   = 0;
         idx     = 0;
         ev_m    = '0;
         seq_m   = '0;
         drops_m = '0;
         ovf_m   = 0;
         cyc_m   = '0;
      end else begin
         sz_m   = fq.size();
         popn_m = !act_v && sz_m > 0;
         if (act_v && rd_if.rd_ready) begin
            if (idx == act.n - 1) act_v = 0;
            else idx++;
         end
         if (ev_m != 0) begin
            if (sz_m < DEPTH) begin
               fq.push_back(mk(ev_m, commitevent, validevent, seq_m, cyc_m));
               seq_m++;
            end else begin
               if (drops_m != 32'hFFFF_FFFF) drops_m++;
               ovf_m = 1;
            end
         end
         if (clr_stats) begin
            drops_m = '0;
            ovf_m   = 0;
         end
         if (popn_m) begin
            act   = fq.pop_front();
            act_v = 1;
            idx   = 0;
         end
         ev_m  = en ? event_valid : 7'h00;
         cyc_m = cyc_m + 64'd1;
      end
   end

   // continuous comparison against the model
   always @(negedge clk) begin
      chk("rd_valid", 64'(rd_if.rd_valid), 64'(act_v));
      if (act_v) begin
         chk("rd_data", rd_if.rd_data, act.w[idx]);
         chk("rd_last", 64'(rd_if.rd_last), 64'(idx == act.n - 1));
      end
      chk("rec_count", 64'(rec_count), 64'(fq.size()));
      chk("drop_count", 64'(drop_count), 64'(drops_m));
      chk("overflow", 64'(overflow), 64'(ovf_m));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [6:0] ev, input logic [127:0] c,
                       input logic [199:0] v);
      event_valid = ev;
      tick();
      event_valid = '0;
      commitevent = c;
      validevent  = v;
      tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((act_v || fq.size() != 0 || ev_m != 0) && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL drain_timeout got %0d exp <400", n);
      end
      tick();
   endtask

   localparam logic [127:0] C1 =
      {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
   localparam logic [127:0] C2 =
      {64'hC0DE_0000_0000_00C1, 64'hC0DE_0000_0000_00C2};
   localparam logic [199:0] V1 =
      {8'h5A, 64'hAAAA_0001_0000_0001, 64'hBBBB_0002_0000_0002,
       64'hCCCC_0003_0000_0003};
`ifdef TRACE_TIMESTAMP_EN
   localparam logic [63:0] H_COMMIT = 64'hA502_6800_0000_0000;
   localparam logic [63:0] H_STORE  = 64'hA522_E800_0000_0001;
   localparam logic [63:0] H_MULTI  = 64'hA50C_3800_0000_0002;
   localparam logic        LAST2    = 1'b0;
   localparam logic        LAST0    = 1'b0;
`else
   localparam logic [63:0] H_COMMIT = 64'hA502_4000_0000_0000;
   localparam logic [63:0] H_STORE  = 64'hA522_C000_0000_0001;
   localparam logic [63:0] H_MULTI  = 64'hA50C_1000_0000_0002;
   localparam logic        LAST2    = 1'b1;
   localparam logic        LAST0    = 1'b1;
`endif

   initial begin
      rst         = 1'b1;
      en          = 1'b1;
      event_valid = '0;
      commitevent = '0;
      validevent  = '0;
      clr_stats   = 1'b0;
      rd_if.rd_ready = 1'b1;
      repeat (3) tick();
      chk("reset_rd_valid", 64'(rd_if.rd_valid), 64'd0);
      chk("reset_rec_count", 64'(rec_count), 64'd0);
      chk("reset_drop", 64'(drop_count), 64'd0);
      chk("reset_ovf", 64'(overflow), 64'd0);
      rst = 1'b0;
      tick();

      // commit only: header three cycles after the event
      send(7'h01, C1, '0);
      tick();
      chk("commit_hdr", rd_if.rd_data, H_COMMIT);
      chk("commit_hdr_valid", 64'(rd_if.rd_valid), 64'd1);
      tick();
      chk("commit_w1", rd_if.rd_data, 64'h1111_1111_1111_1111);
      tick();
      chk("commit_w2", rd_if.rd_data, 64'h2222_2222_2222_2222);
      chk("commit_w2_last", 64'(rd_if.rd_last), 64'(LAST2));
      drain();

      // store + commit with a 10-cycle stall mid-record
      send(7'h11, C2, V1);
      tick();
      chk("store_hdr", rd_if.rd_data, H_STORE);
      tick();
      tick();
      rd_if.rd_ready = 1'b0;
      repeat (10) tick();
      chk("stall_word", rd_if.rd_data, 64'hC0DE_0000_0000_00C2);
      chk("stall_last", 64'(rd_if.rd_last), 64'd0);
      rd_if.rd_ready = 1'b1;
      tick();
      chk("resume_word", rd_if.rd_data, 64'h0000_0000_0000_005A);
      drain();

      // two secondaries: header-only record
      send(7'h06, C1, V1);
      tick();
      chk("multi_hdr", rd_if.rd_data, H_MULTI);
      chk("multi_last", 64'(rd_if.rd_last), 64'(LAST0));
      drain();

      // capture disabled: nothing is queued
      en = 1'b0;
      send(7'h01, C1, '0);
      repeat (2) tick();
      chk("en_off_count", 64'(rec_count), 64'd0);
      chk("en_off_valid", 64'(rd_if.rd_valid), 64'd0);
      en = 1'b1;
      drain();

      // overflow: one record held, 20 commits against a full FIFO
      rd_if.rd_ready = 1'b0;
      send(7'h06, '0, '0);
      for (int i = 0; i < 21; i++) begin
         event_valid = (i < 20) ? 7'h01 : 7'h00;
         commitevent = {64'(i), 64'(i + 100)};
         tick();
      end
      chk("ovf_count", 64'(rec_count), 64'd16);
      chk("ovf_drops", 64'(drop_count), 64'd4);
      chk("ovf_flag", 64'(overflow), 64'd1);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      chk("clr_drops", 64'(drop_count), 64'd0);
      chk("clr_flag", 64'(overflow), 64'd0);
      rd_if.rd_ready = 1'b1;
      drain();

      // reset during a payload word
      send(7'h11, C2, V1);
      tick();
      tick();
      chk("pre_rst_valid", 64'(rd_if.rd_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_valid", 64'(rd_if.rd_valid), 64'd0);
      chk("rst_count", 64'(rec_count), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      send(7'h01, C1, '0);
      tick();
      chk("post_rst_hdr", rd_if.rd_data, H_COMMIT);
      drain();

`ifdef TRACE_TIMESTAMP_EN
      // stamps of two pushes five cycles apart
      send(7'h01, C1, '0);
      repeat (3) tick();
      send(7'h01, C2, '0);
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/trace_record_packer.md
Name: trace_record_packer

Overview:
- Downstream consumer of the difftest event-change stage.
- Takes the registered commit payload (128b), the selected secondary payload (200b) and the raw event-valid vector.
- Builds framed trace records, buffers them in a record FIFO, and serializes each record into 64-bit words on a valid/ready read port.
- The AXI-lite/DMA readout logic drains that port.

Parameters:
- DEPTH, 16, record-FIFO entries; power of two, ≥2.
- DROP_W, 32, width of saturating drop counter.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous, active-high reset
- en  in  1  capture enable; when low, no new records are pushed and draining continues
- event_valid  in  7  raw vector {0,trap,store,rf,delay,arch,commit}; one cycle ahead of payloads
- commitevent  in  128  registered commit payload
- validevent  in  200  registered secondary payload (arch/delay/rf/store/trap)
- rd_data  out  64  current serialized word
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts word
- rd_last  out  1  rd_data is the final word of a record
- rec_count  out  $clog2(DEPTH)+1  records held in the FIFO
- drop_count  out  DROP_W  records lost because the FIFO was full; saturating
- overflow  out  1  sticky; set on first drop
- clr_stats  in  1  synchronous clear of drop_count and overflow

Behaviour:
- Reset: all outputs 0; FIFO empty; seq=0; serializer IDLE; ev_d=0. Reset mid-record discards the partial record and rd_valid drops immediately.
- Alignment:
  - ev_d <= en ? event_valid : 0 on every clock.
  - Payloads are sampled in the cycle where ev_d is nonzero (upstream registers one cycle late).
- Record build, same cycle as ev_d≠0:
  - C = ev_d[0].
  - S = ev_d[5:1] is one-hot.
  - M = ev_d[5:1] is nonzero and not one-hot.
  - nwords = 2·C + 4·S (0, 2, 4 or 6).
- Header word:
  - [63:56] = 8'hA5
  - [55:49] = ev_d
  - [48:45] = nwords
  - [44] = M
  - [43] = timestamp flag
  - [42:32] = 0
  - [31:0] = seq
- Payload order:
  - If C: commitevent[127:64], then commitevent[63:0].
  - If S: {56'b0,validevent[199:192]}, [191:128], [127:64], [63:0].
- Push/drop:
  - Push the record if rec_count < DEPTH at that edge. A pop in the same cycle does not free space for the push.
  - On push, seq increments (wraps at 2^32).
  - Otherwise the record is dropped: drop_count +1 (saturating at all-ones), overflow <= 1. seq is not incremented.
  - clr_stats wins over a simultaneous drop.
- Serializer FSM:
  - IDLE: FIFO non-empty → pop entry into a holding register; → HDR.
  - HDR: rd_valid=1, rd_data=header. On rd_ready: if nwords==0 → IDLE, otherwise → PAY with idx=0. rd_last=1 in HDR only when nwords==0.
  - PAY: rd_data = payload[idx]. On rd_ready: idx+1. At idx==nwords−1, rd_last=1 and the handshake → IDLE.
  - A pop from the FIFO happens only in IDLE. There is one idle cycle between records.
- rd_data and rd_last hold stable while rd_valid && !rd_ready.
- Latency: with the FIFO empty and the FSM in IDLE, event_valid asserted in cycle N gives the header on rd_data in cycle N+3.
- en is sampled only via ev_d; records already queued always drain.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined:
  - A 64-bit free-running cycle counter runs (reset 0, wraps).
  - Its value at the push edge is stored with the record and emitted as the last payload word.
  - Header nwords += 1 and [43] = 1.
- Undefined:
  - No counter; FIFO entry is narrower; [43] = 0; nwords as above.

Decomposition:
- Package trace_pkg holds:
  - TRACE_MAGIC = 8'hA5
  - header field offsets/widths
  - payload widths (128, 200)
  - the record-entry struct type {ev, payloads, seq, ts}
- Sub-module trace_rec_fifo: synchronous FIFO of DEPTH entries with full/empty/count outputs, async active-high reset.
- Framing and serializer stay in the top.

Test Plan:
- Commit only: event_valid=7'h01 at N, commitevent=128'h1111…_2222… at N+1 → header at N+3 = 0xA5 | ev 0x01 | nwords 2 | seq 0; then two payload words, rd_last on the second.
- Store + commit: event_valid=7'h11, validevent fixed pattern → nwords 6; word order matches the payload order above; seq increments to 1.
- Multi-secondary: event_valid=7'h06 → M=1, nwords 0, single-word record with rd_last=1 on the header.
- Backpressure: rd_ready held low 10 cycles mid-record → rd_data/rd_last stable; no words lost; correct resume.
- Overflow: rd_ready=0 and 20 single-cycle commits with DEPTH=16 → rec_count=16, drop_count=4, overflow=1; clr_stats → both 0; draining yields seq 0..15 contiguous.
- Reset mid-record: assert s_axi_aresetn during PAY → rd_valid=0 immediately, rec_count=0, seq restarts at 0. With TRACE_TIMESTAMP_EN defined, check header [43]=1 and the timestamp difference between consecutive pushes equals the cycle gap.
